// File: rtl/uart_tx.sv
// UART transmit serializer: frames a parallel word (start, LSB-first data,
// optional parity, 1-2 stop bits) with one bit per baud tick from the divider.
module uart_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clk_tx,
    input  logic                 i_tx_valid,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_tx_busy,
    output logic                 o_txd,
    output logic                 o_tx_done
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 txd_q, txd_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // State and output registers; reset forces the line idle without a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state and next-output logic; the shift register drains LSB first.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        txd_d      = txd_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (i_tx_valid) begin
                    shift_d  = i_tx_data;
                    parity_d = (^i_tx_data) ^ 1'(PARITY_ODD);
                    state_d  = S_LOAD;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_LOAD: begin
                if (i_clk_tx) begin
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (i_clk_tx) begin
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (i_clk_tx) begin
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        if (PARITY_EN != 0) begin
                            txd_d   = parity_q;
                            state_d = S_PARITY;
                        end else begin
                            txd_d      = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = S_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (i_clk_tx) begin
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (i_clk_tx) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign o_txd      = txd_q;
    assign o_tx_ready = ready_q;
    assign o_tx_busy  = busy_q;
    assign o_tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four parameter variants share clock, tick and data;
// a monitor rebuilds each serial frame per tick and checks it against queued vectors.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [7:0] data;
    logic [3:0] valid;
    logic [3:0] ready, busy, txd, done;
    logic       tick_seen;

    int checks = 0;
    int errors = 0;

    int    exp_id_q[$];
    string exp_bits_q[$];

    bit    cap      [4];
    int    cap_n    [4];
    string cap_str  [4];
    bit    busy_bad [4];
    int    since_done [4];
    int    gap      [4];
    logic [3:0] prev_txd;
    int    phase = 0;

    uart_tx u_dut0 (.clk(clk), .reset(reset), .i_clk_tx(tick), .i_tx_valid(valid[0]), .i_tx_data(data),
                    .o_tx_ready(ready[0]), .o_tx_busy(busy[0]), .o_txd(txd[0]), .o_tx_done(done[0]));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (.clk(clk), .reset(reset), .i_clk_tx(tick),
                    .i_tx_valid(valid[1]), .i_tx_data(data), .o_tx_ready(ready[1]), .o_tx_busy(busy[1]),
                    .o_txd(txd[1]), .o_tx_done(done[1]));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (.clk(clk), .reset(reset), .i_clk_tx(tick),
                    .i_tx_valid(valid[2]), .i_tx_data(data), .o_tx_ready(ready[2]), .o_tx_busy(busy[2]),
                    .o_txd(txd[2]), .o_tx_done(done[2]));
    uart_tx #(.STOP_BITS(2)) u_dut3 (.clk(clk), .reset(reset), .i_clk_tx(tick),
                    .i_tx_valid(valid[3]), .i_tx_data(data), .o_tx_ready(ready[3]), .o_tx_busy(busy[3]),
                    .o_txd(txd[3]), .o_tx_done(done[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick: one-clk pulse every 8 clks, changed just after the rising edge.
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            phase = (phase + 1) % 8;
            tick  = (phase == 0);
        end
    end

    always @(posedge clk) tick_seen <= tick;

    function automatic int flen(input int id);
        return (id == 0) ? 10 : 11;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: one line sample per tick; frame ends at the tick that must raise done.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                cap[i]        = 1'b0;
                cap_n[i]      = 0;
                cap_str[i]    = "";
                busy_bad[i]   = 1'b0;
                since_done[i] = 0;
            end
            exp_id_q.delete();
            exp_bits_q.delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (txd[i] != prev_txd[i])
                    chk($sformatf("txd_change_on_tick dut%0d", i), int'(tick_seen), 1);
                if (done[i])
                    chk($sformatf("done_align dut%0d", i),
                        int'(cap[i] && cap_n[i] == flen(i) && tick_seen && ready[i] && !busy[i]), 1);
                if (tick_seen) begin
                    if (cap[i] && cap_n[i] == flen(i)) begin
                        chk($sformatf("done_at_final_tick dut%0d", i), int'(done[i]), 1);
                        chk($sformatf("busy_through_frame dut%0d", i), int'(busy_bad[i]), 0);
                        checks++;
                        if (exp_id_q.size() == 0) begin
                            errors++;
                            $display("FAIL frame dut%0d: got %s expected no frame", i, cap_str[i]);
                        end else begin
                            int    eid;
                            string ebits;
                            eid   = exp_id_q.pop_front();
                            ebits = exp_bits_q.pop_front();
                            if (eid != i || cap_str[i] != ebits) begin
                                errors++;
                                $display("FAIL frame dut%0d: got %s expected dut%0d %s", i, cap_str[i], eid, ebits);
                            end
                        end
                        cap[i]        = 1'b0;
                        since_done[i] = 0;
                    end else if (cap[i]) begin
                        if (txd[i]) cap_str[i] = {cap_str[i], "1"};
                        else        cap_str[i] = {cap_str[i], "0"};
                        cap_n[i]++;
                        if (!busy[i]) busy_bad[i] = 1'b1;
                    end else if (!txd[i]) begin
                        cap[i]      = 1'b1;
                        cap_n[i]    = 1;
                        cap_str[i]  = "0";
                        busy_bad[i] = !busy[i];
                        gap[i]      = since_done[i];
                    end else begin
                        since_done[i]++;
                    end
                end
            end
        end
        prev_txd = txd;
    end

    task automatic wait_for(input int id, input bit sel_done, input logic val, input string name);
        int t = 0;
        while (((sel_done ? done[id] : ready[id]) !== val) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            checks++;
            errors++;
            $display("FAIL timeout %s: got no event expected within 400 clks", name);
        end
    endtask

    task automatic push(input int id, input string bits);
        exp_id_q.push_back(id);
        exp_bits_q.push_back(bits);
    endtask

    task automatic send(input int id, input logic [7:0] d, input string bits);
        @(negedge clk);
        data      = d;
        valid[id] = 1'b1;
        push(id, bits);
        @(negedge clk);
        wait_for(id, 1'b0, 1'b0, "accept");
        chk($sformatf("busy_after_accept dut%0d", id), int'(busy[id]), 1);
        valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (exp_id_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("frames_drained", exp_id_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        valid = '0;
        data  = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_txd dut%0d", i),   int'(txd[i]),   1);
            chk($sformatf("reset_ready dut%0d", i), int'(ready[i]), 1);
            chk($sformatf("reset_busy dut%0d", i),  int'(busy[i]),  0);
            chk($sformatf("reset_done dut%0d", i),  int'(done[i]),  0);
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Basic frame, even and odd parity.
        send(0, 8'hA5, "0101001011");
        wait_idle();
        send(1, 8'h07, "01110000011");
        wait_idle();
        send(2, 8'h07, "01110000001");
        wait_idle();

        // Two stop bits; valid held and data changed after acceptance.
        @(negedge clk);
        data     = 8'h00;
        valid[3] = 1'b1;
        push(3, "00000000011");
        @(negedge clk);
        wait_for(3, 1'b0, 1'b0, "accept_hold");
        data = 8'hFF;
        repeat (30) @(negedge clk);
        valid[3] = 1'b0;
        data     = 8'h00;
        wait_idle();

        // Back-to-back frames with valid held high across the done edge.
        @(negedge clk);
        data     = 8'h55;
        valid[0] = 1'b1;
        push(0, "0101010101");
        push(0, "0111100001");
        @(negedge clk);
        wait_for(0, 1'b0, 1'b0, "accept_b2b_first");
        data = 8'h0F;
        wait_for(0, 1'b1, 1'b1, "done_b2b_first");
        @(negedge clk);
        wait_for(0, 1'b0, 1'b0, "accept_b2b_second");
        valid[0] = 1'b0;
        wait_idle();
        chk("b2b_idle_ticks_between", gap[0], 0);

        // Acceptance coincident with a tick: that tick must not start the frame.
        begin
            int t = 0;
            @(negedge clk);
            while (!tick && t < 20) begin
                @(negedge clk);
                t++;
            end
            data     = 8'h81;
            valid[0] = 1'b1;
            push(0, "0100000011");
            @(negedge clk);
            valid[0] = 1'b0;
            chk("tick_accept_ready", int'(ready[0]), 0);
            chk("tick_accept_txd_high", int'(txd[0]), 1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!tick_seen && t < 20);
            chk("start_at_next_tick", int'(txd[0]), 0);
        end
        wait_idle();

        // Reset in the middle of data bit 3, then a clean frame.
        send(0, 8'h00, "0000000001");
        begin
            int t = 0;
            while (cap_n[0] != 5 && t < 400) begin
                @(negedge clk);
                t++;
            end
            chk("reached_data_bit3", cap_n[0], 5);
        end
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_txd", int'(txd[0]), 1);
        chk("abort_ready", int'(ready[0]), 1);
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_done", int'(done[0]), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        send(0, 8'h3C, "0001111001");
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit serializer that sits directly downstream of the baud divider and consumes its one-cycle transmit tick (o_clk_tx, 651-clock period).
- Accepts a parallel byte over a valid/ready handshake.
- Emits LSB-first on o_txd: start bit, DATA_BITS data bits, optional parity, then 1 or 2 stop bits.
- Each serial bit lasts exactly one tick interval.

Parameters:
DATA_BITS, 8, data bits per frame (legal 5..9)
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits (legal 1 or 2)

Ports:
clk  input  1  system clock; the only clock
reset  input  1  asynchronous, active-low reset
i_clk_tx  input  1  baud tick from divider, one-clk pulse per bit period; every high cycle counts as one tick
i_tx_valid  input  1  data valid
i_tx_data  input  DATA_BITS  byte to send; sampled only at acceptance
o_tx_ready  output  1  registered; high only in IDLE
o_tx_busy  output  1  registered; high in every state except IDLE
o_txd  output  1  serial line, registered, idle high
o_tx_done  output  1  one-clk pulse at frame end

Behaviour:
Reset (async, reset=0): state=IDLE, o_txd=1, o_tx_ready=1, o_tx_busy=0, o_tx_done=0, shift/bit/stop counters=0.
- A reset mid-frame aborts the frame; o_txd returns high immediately, with no clock needed.

State machine and transitions:
- IDLE: o_txd=1.
  - Ticks are ignored.
  - On a clock edge with i_tx_valid=1: latch i_tx_data into the shift register, compute the parity bit, go to LOAD.
  - o_tx_ready=0 and o_tx_busy=1 from the following cycle.
- LOAD: waits for the first tick, which aligns the start bit to the baud grid.
  - On tick: o_txd<=0, go to START.
  - A tick in the same cycle as acceptance does NOT count; the first tick counted is the one after entering LOAD.
- START: on tick: o_txd<=data[0], bit_cnt<=0, go to DATA.
- DATA: on tick:
  - If bit_cnt==DATA_BITS-1: go to PARITY with o_txd<=parity when PARITY_EN=1; otherwise go to STOP with o_txd<=1 and stop_cnt<=0.
  - Otherwise: bit_cnt++, o_txd<=data[bit_cnt+1].
- PARITY: on tick: o_txd<=1, stop_cnt<=0, go to STOP.
  - Parity = XOR of all data bits; inverted when PARITY_ODD=1.
- STOP: on tick:
  - If stop_cnt==STOP_BITS-1: go to IDLE, o_tx_done<=1 for exactly one clk, o_tx_ready<=1, o_tx_busy<=0.
  - Otherwise: stop_cnt++.

Frame timing:
- Frame length = 1+DATA_BITS+PARITY_EN+STOP_BITS tick intervals, measured from the LOAD tick to the final STOP tick.
- o_txd changes only on clock edges where i_clk_tx=1, except at reset.

Handshake and data rules:
- i_tx_valid while busy is ignored, with no queueing.
- Changes to i_tx_data after acceptance do not affect the frame in flight.

Back-to-back frames:
- In the done cycle, state is IDLE with ready=1.
- If valid is high in that cycle, the next byte is accepted at that edge and enters LOAD.
- The line stays high (stop level) until the next tick, so there is no extra idle bit beyond that alignment.

Counter widths: bit_cnt is ceil(log2(DATA_BITS)) bits; stop_cnt is 1 bit. No wrap is possible within legal parameters.

Test Plan:
Bench drives i_clk_tx as a 1-clk pulse every 8 clks for speed; reset is active-low.
1. Default params; send 0xA5 → o_txd per tick interval: 0,1,0,1,0,0,1,0,1,1. o_tx_done pulses once, 1 clk, at the final stop tick; ready returns 1 on the same edge; busy high throughout.
2. PARITY_EN=1, PARITY_ODD=0; send 0x07 → parity bit = 1, giving 11 intervals. Rerun with PARITY_ODD=1 → parity bit = 0.
3. STOP_BITS=2; send 0x00 → start plus eight 0 data bits, then o_txd high for 2 tick intervals before done, 11 intervals total. Valid held high after accept, with i_tx_data changed to 0xFF, does not alter the frame.
4. Back-to-back: valid held high with 0x55 then 0x0F → second byte accepted at the done edge; its start bit begins at the next tick; serial stream is exactly the two concatenated frames.
5. Valid asserted together with a tick while in IDLE → that tick is ignored; start bit begins at the following tick.
6. Reset asserted during data bit 3 of 0x00 → o_txd=1, ready=1, busy=0, done=0 immediately. After release, sending 0x3C produces a correct frame.
